// File: rtl/l2_cmd_pkg.sv
// l2_cmd_pkg: shared command codes, FSM states and address width for the L1->L2 responder
package l2_cmd_pkg;
  localparam int L2_ADDR_W = 26;
  localparam logic [1:0] L2_CMD_NOP   = 2'b00;
  localparam logic [1:0] L2_CMD_READ  = 2'b01;
  localparam logic [1:0] L2_CMD_WRITE = 2'b10;
  localparam logic [1:0] L2_CMD_RWITM = 2'b11;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} l2_state_t;
endpackage

// File: rtl/l2_sat_counter.sv
// l2_sat_counter: saturating up-counter for traffic statistics
//   clk, rst_n : clock, async active-low reset
//   inc        : count one event this cycle
//   cnt        : current count, sticks at all-ones
module l2_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/l2_cmd_responder.sv
// l2_cmd_responder: L2-side responder with fixed access latency and a small backing store
//   cmd_valid/cmd_ready, command_in, address_in, wr_data : L1 command channel
//   resp_valid/resp_ready, resp_cmd, resp_addr, resp_data : response beat to L1
//   rd_cnt, wr_cnt, rwitm_cnt : saturating counts of accepted commands
module l2_cmd_responder
  import l2_cmd_pkg::*;
#(
  parameter int ADDR_W  = L2_ADDR_W,
  parameter int DATA_W  = 32,
  parameter int IDX_W   = 4,
  parameter int LATENCY = 4,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        command_in,
  input  logic [ADDR_W-1:0] address_in,
  input  logic [DATA_W-1:0] wr_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [1:0]        resp_cmd,
  output logic [ADDR_W-1:0] resp_addr,
  output logic [DATA_W-1:0] resp_data,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic [CNT_W-1:0]  rwitm_cnt
);
  l2_state_t state, state_nx;
  logic [3:0] lat_cnt;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] mem [2**IDX_W];
  logic accept;
  assign accept = cmd_valid && state == IDLE && command_in != L2_CMD_NOP;
  always_comb begin
    cmd_ready  = state == IDLE;
    resp_valid = state == RESP;
    state_nx   = state == IDLE ? (accept ? BUSY : IDLE) :
                 state == BUSY ? (lat_cnt == 4'd0 ? RESP : BUSY) :
                 (resp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // resp_cmd/resp_addr double as the latched command; resp_data is cleared on accept so WRITE answers 0
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      resp_cmd  <= '0;
      resp_addr <= '0;
      resp_data <= '0;
      wdata_q   <= '0;
      lat_cnt   <= '0;
      for (int i = 0; i < 2**IDX_W; i++) mem[i] <= '0;
    end else if (accept) begin
      resp_cmd  <= command_in;
      resp_addr <= address_in;
      resp_data <= '0;
      wdata_q   <= wr_data;
      lat_cnt   <= 4'(LATENCY - 1);
    end else if (state == BUSY) begin
      lat_cnt <= lat_cnt - 4'd1;
      if (lat_cnt == 4'd0 && resp_cmd == L2_CMD_WRITE) mem[resp_addr[IDX_W-1:0]] <= wdata_q;
      else if (lat_cnt == 4'd0) resp_data <= mem[resp_addr[IDX_W-1:0]];
    end
  l2_sat_counter #(.CNT_W(CNT_W)) u_rd    (.clk(clk), .rst_n(rst_n), .inc(accept && command_in == L2_CMD_READ),  .cnt(rd_cnt));
  l2_sat_counter #(.CNT_W(CNT_W)) u_wr    (.clk(clk), .rst_n(rst_n), .inc(accept && command_in == L2_CMD_WRITE), .cnt(wr_cnt));
  l2_sat_counter #(.CNT_W(CNT_W)) u_rwitm (.clk(clk), .rst_n(rst_n), .inc(accept && command_in == L2_CMD_RWITM), .cnt(rwitm_cnt));
endmodule

// File: tb/tb_l2_cmd_responder.sv
// tb_l2_cmd_responder: randomized self-checking bench with a behavioural memory/counter model
module tb_l2_cmd_responder;
  localparam int LAT = 4;
  localparam int SMAX = 3;
  logic clk = 0, rst_n = 0, cmd_valid = 0, resp_ready = 0;
  logic [1:0] command_in = 0;
  logic [25:0] address_in = 0;
  logic [31:0] wr_data = 0;
  logic cmd_ready, resp_valid, cmd_ready2, resp_valid2;
  logic [1:0] resp_cmd, resp_cmd2;
  logic [25:0] resp_addr, resp_addr2;
  logic [31:0] resp_data, resp_data2;
  logic [15:0] rd_cnt, wr_cnt, rwitm_cnt;
  logic [1:0] rd_cnt2, wr_cnt2, rwitm_cnt2;
  int checks = 0, errs = 0, cyc = 0, last_acc = 0;
  int n_rd = 0, n_wr = 0, n_rw = 0;
  logic [31:0] mem_m [16];
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  l2_cmd_responder #(.LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .command_in(command_in), .address_in(address_in), .wr_data(wr_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_cmd(resp_cmd),
    .resp_addr(resp_addr), .resp_data(resp_data),
    .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .rwitm_cnt(rwitm_cnt));
  // Narrow-counter twin fed the same traffic, used to observe saturation
  l2_cmd_responder #(.LATENCY(LAT), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2),
    .command_in(command_in), .address_in(address_in), .wr_data(wr_data),
    .resp_valid(resp_valid2), .resp_ready(resp_ready), .resp_cmd(resp_cmd2),
    .resp_addr(resp_addr2), .resp_data(resp_data2),
    .rd_cnt(rd_cnt2), .wr_cnt(wr_cnt2), .rwitm_cnt(rwitm_cnt2));

  function automatic int sat(input int n);
    return n > SMAX ? SMAX : n;
  endfunction

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 0;
    cmd_valid = 0;
    resp_ready = 0;
    for (int i = 0; i < 16; i++) mem_m[i] = 0;
    n_rd = 0; n_wr = 0; n_rw = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic check_counters(input string tag);
    checks++;
    if (rd_cnt !== 16'(n_rd) || wr_cnt !== 16'(n_wr) || rwitm_cnt !== 16'(n_rw)) begin
      errs++;
      $display("FAIL %s counters: got rd=%0d wr=%0d rwitm=%0d expected rd=%0d wr=%0d rwitm=%0d",
               tag, rd_cnt, wr_cnt, rwitm_cnt, n_rd, n_wr, n_rw);
    end
    checks++;
    if (rd_cnt2 !== 2'(sat(n_rd)) || wr_cnt2 !== 2'(sat(n_wr)) || rwitm_cnt2 !== 2'(sat(n_rw))) begin
      errs++;
      $display("FAIL %s sat_counters: got rd=%0d wr=%0d rwitm=%0d expected rd=%0d wr=%0d rwitm=%0d",
               tag, rd_cnt2, wr_cnt2, rwitm_cnt2, sat(n_rd), sat(n_wr), sat(n_rw));
    end
  endtask

  // Entered just after a negedge with the DUT idle
  task automatic do_cmd(input logic [1:0] c, input logic [25:0] a, input logic [31:0] d, input int stall);
    logic [31:0] exp_d;
    logic [1:0] s_cmd;
    logic [25:0] s_addr;
    logic [31:0] s_data;
    int lat;
    cmd_valid = 1; command_in = c; address_in = a; wr_data = d;
    checks++;
    if (cmd_ready !== 1'b1) begin errs++; $display("FAIL cmd_ready_idle: got %b expected 1", cmd_ready); end
    @(posedge clk);
    last_acc = cyc;
    exp_d = (c == 2'b10) ? 32'h0 : mem_m[a[3:0]];
    if (c == 2'b10) mem_m[a[3:0]] = d;
    n_rd += (c == 2'b01); n_wr += (c == 2'b10); n_rw += (c == 2'b11);
    @(negedge clk);
    cmd_valid = 0; command_in = 2'($urandom); address_in = 26'($urandom); wr_data = $urandom;
    lat = 0;
    while (!resp_valid && lat < 40) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    checks++;
    if (lat != LAT) begin errs++; $display("FAIL latency: got %0d expected %0d", lat, LAT); end
    checks++;
    if (resp_cmd !== c || resp_addr !== a || resp_data !== exp_d) begin
      errs++;
      $display("FAIL resp_fields: got cmd=%b addr=%h data=%h expected cmd=%b addr=%h data=%h",
               resp_cmd, resp_addr, resp_data, c, a, exp_d);
    end
    checks++;
    if (cmd_ready !== 1'b0) begin errs++; $display("FAIL cmd_ready_resp: got %b expected 0", cmd_ready); end
    s_cmd = resp_cmd; s_addr = resp_addr; s_data = resp_data;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (resp_valid !== 1'b1 || cmd_ready !== 1'b0 || resp_cmd !== s_cmd || resp_addr !== s_addr || resp_data !== s_data) begin
        errs++;
        $display("FAIL stall_hold: got valid=%b ready=%b cmd=%b addr=%h data=%h expected valid=1 ready=0 cmd=%b addr=%h data=%h",
                 resp_valid, cmd_ready, resp_cmd, resp_addr, resp_data, s_cmd, s_addr, s_data);
      end
    end
    resp_ready = 1;
    @(posedge clk); @(negedge clk);
    resp_ready = 0;
    checks++;
    if (resp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errs++;
      $display("FAIL handshake: got valid=%b ready=%b expected valid=0 ready=1", resp_valid, cmd_ready);
    end
    check_counters("post_cmd");
  endtask

  task automatic test_reset();
    reset_dut();
    checks++;
    if (resp_cmd !== 0 || resp_addr !== 0 || resp_data !== 0) begin
      errs++;
      $display("FAIL reset_resp: got cmd=%b addr=%h data=%h expected 0", resp_cmd, resp_addr, resp_data);
    end
    check_counters("reset");
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1 || resp_valid !== 1'b0) begin
        errs++;
        $display("FAIL reset_idle: got ready=%b valid=%b expected ready=1 valid=0", cmd_ready, resp_valid);
      end
    end
  endtask

  task automatic test_write_read();
    do_cmd(2'b10, 26'h0000005, 32'hDEADBEEF, 0);
    do_cmd(2'b01, 26'h0000005, 32'h0, 0);
  endtask

  task automatic test_rwitm_alias();
    do_cmd(2'b11, 26'h3FFFFF5, 32'h0, 0);
    checks++;
    if (rwitm_cnt !== 16'd1) begin errs++; $display("FAIL rwitm_cnt: got %0d expected 1", rwitm_cnt); end
  endtask

  task automatic test_stall();
    do_cmd(2'b01, 26'h1234567, 32'h0, 10);
  endtask

  task automatic test_nop();
    cmd_valid = 1; command_in = 2'b00;
    repeat (3) begin
      address_in = 26'($urandom);
      @(posedge clk); @(negedge clk);
      checks++;
      if (resp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
        errs++;
        $display("FAIL nop: got valid=%b ready=%b expected valid=0 ready=1", resp_valid, cmd_ready);
      end
    end
    cmd_valid = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0) begin errs++; $display("FAIL nop_late: got valid=%b expected 0", resp_valid); end
    check_counters("nop");
  endtask

  task automatic test_reset_abort();
    cmd_valid = 1; command_in = 2'b10; address_in = 26'h2; wr_data = 32'h1;
    @(posedge clk); @(negedge clk);
    cmd_valid = 0;
    @(posedge clk); @(negedge clk);
    rst_n = 0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || resp_valid !== 1'b0 || wr_cnt !== 0) begin
      errs++;
      $display("FAIL async_reset: got ready=%b valid=%b wr_cnt=%0d expected ready=1 valid=0 wr_cnt=0",
               cmd_ready, resp_valid, wr_cnt);
    end
    for (int i = 0; i < 16; i++) mem_m[i] = 0;
    n_rd = 0; n_wr = 0; n_rw = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    do_cmd(2'b01, 26'h2, 32'h0, 0);
    checks++;
    if (wr_cnt !== 16'd0) begin errs++; $display("FAIL abort_wr_cnt: got %0d expected 0", wr_cnt); end
  endtask

  task automatic test_saturate();
    repeat (5) do_cmd(2'b01, 26'($urandom), 32'h0, 0);
    checks++;
    if (rd_cnt2 !== 2'b11) begin errs++; $display("FAIL rd_saturate: got %0d expected 3", rd_cnt2); end
  endtask

  task automatic test_back_to_back();
    int t0;
    do_cmd(2'b10, 26'h7, 32'hA5A5_0001, 0);
    t0 = last_acc;
    do_cmd(2'b01, 26'h7, 32'h0, 0);
    checks++;
    if (last_acc - t0 != LAT + 2) begin
      errs++;
      $display("FAIL throughput: got %0d cycles expected %0d", last_acc - t0, LAT + 2);
    end
  endtask

  task automatic test_random();
    repeat (40) begin
      do_cmd(2'($urandom_range(1, 3)), {22'($urandom), 4'($urandom_range(0, 3))}, $urandom, $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_rwitm_alias();
    test_stall();
    test_nop();
    test_reset_abort();
    test_saturate();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule
